led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//   Shares the board's 8-bit LED bank between N_SRC display requesters (switch mirror, CAN node
//   status, error counters, heartbeat). Time-multiplexed round-robin grant with minimum hold time.
//   Debounced push-button forces advance; lock switch pins the current owner. Sits in the SoC top
//   on the divided clock, between the display sources and the led output pins.
// PARAMETERS
//   N_SRC           4           number of requesters (2..8)
//   DATA_W          8           LED/data width
//   HOLD_CYCLES     25_000_000  minimum grant time, clk cycles (>=1)
//   DEBOUNCE_CYCLES 1_000_000   cycles btn_next must be stable before accepted (>=1)
// PORTS
//   clk        in   1               system clock (divided clock)
//   rst        in   1               synchronous reset, active-low
//   req        in   N_SRC           per-source display request, level
//   data       in   N_SRC*DATA_W    source i pattern on data[i*DATA_W +: DATA_W]
//   btn_next   in   1               raw async push-button, active-high
//   sw_lock    in   1               1 = freeze current owner (level, sync by user)
//   led        out  DATA_W          LED bank drive, registered
//   grant      out  N_SRC           one-hot owner, registered; 0 when idle
//   owner      out  $clog2(N_SRC)   index of current owner; 0 when idle
//   active     out  1               1 while a source owns the bank
// BEHAVIOUR
//   Reset (rst==0 at posedge): led=0, grant=0, owner=0, active=0, rr pointer=N_SRC-1, hold_cnt=0,
//     debounce state cleared, FSM=IDLE. Reset mid-grant aborts immediately, no output glitch.
//   btn_next: 2-FF synchroniser; counter must see stable level for DEBOUNCE_CYCLES consecutive
//     cycles to update debounced level; 0->1 of debounced level = one-cycle next_pulse.
//     Total press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
//   Round-robin pick: first i with req[i]=1 scanning ptr+1, ptr+2, ... mod N_SRC; ptr=last owner.
//   FSM:
//     IDLE: grant=0, led=0. If |req: pick winner w; next cycle grant=onehot(w), owner=w, active=1,
//       hold_cnt=HOLD_CYCLES-1, ptr=w -> SHOW. Arbitration latency: 1 cycle.
//     SHOW: led <= data[owner] every cycle (1-cycle latency data->led). hold_cnt decrements to 0 and
//       saturates. Evaluated in priority order each cycle:
//       1. req[owner]==0 -> release: if another req, regrant to RR winner next cycle; else IDLE.
//          Applies even when sw_lock=1 and before hold expires.
//       2. sw_lock==1 -> stay; hold_cnt keeps counting; next_pulse ignored (dropped, not queued).
//       3. next_pulse -> regrant to RR winner excluding owner; if no other req, stay and reload
//          hold_cnt.
//       4. hold_cnt==0 and another req pending -> regrant to RR winner.
//       5. else stay. Sole requester keeps bank indefinitely.
//     Regrant is direct SHOW->SHOW: grant switches in one cycle, never passes through 0;
//       led shows new owner's data on the cycle after grant changes.
//   Simultaneous: owner drop + next_pulse -> rule 1. New req arriving same cycle as release is
//     eligible. req deassert on non-owner: no effect.
//   grant always one-hot or zero; owner/active consistent with grant every cycle.
// TESTING (sim params: N_SRC=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4)
//   1 rst=0 3 cycles, req=4'hF -> led=0, grant=0, active=0 throughout reset; release -> grant=0001
//     one cycle later, led=data[0] next cycle.
//   2 req=4'b1010 held -> grants 0010 then 1000 then 0010, each exactly 8 cycles.
//   3 owner 0 req=0001 only, 30 cycles -> grant stays 0001; raise req[2] -> grant 0100 once
//     hold_cnt==0.
//   4 btn_next pulses 3 cycles (bounce) then held high 6 -> exactly one advance, 6 cycles after stable.
//   5 sw_lock=1, req=1111, btn press, 40 cycles -> owner unchanged; drop req[owner] -> next RR
//     winner granted in 1 cycle despite lock.
//   6 assert rst mid-SHOW with hold_cnt=5 -> all outputs 0 next edge; after release, first grant
//     goes to source 0 (ptr reset).

Source files
------------

// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_bank_arbiter
// Brief    : Round-robin LED bank sharing with hold time, debounced advance
//            button and owner lock.
// Revision : 1.0
// ============================================================================
module led_bank_arbiter #(
  parameter int N_SRC           = 4,
  parameter int DATA_W          = 8,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          i_req,
  input  logic [N_SRC*DATA_W-1:0]   i_data,
  input  logic                      i_btn_next,
  input  logic                      i_sw_lock,
  output logic [DATA_W-1:0]         o_led,
  output logic [N_SRC-1:0]          o_grant,
  output logic [$clog2(N_SRC)-1:0]  o_owner,
  output logic                      o_active
);

  localparam int OW = $clog2(N_SRC);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [HW-1:0] c_HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] c_DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [OW-1:0] c_PTR_RESET   = OW'(N_SRC - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SHOW = 1'b1;

  // --------------------------------------------------------------------------
  // Button synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic          r_btn_meta;
  logic          r_btn_sync;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic [DW-1:0] r_db_cnt;
  logic          w_next_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_meta <= i_btn_next;
      r_btn_sync <= r_btn_meta;
      r_btn_db_d <= r_btn_db;
      // Any sample matching the accepted level restarts the stability window.
      if (r_btn_sync != r_btn_db) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_btn_db <= r_btn_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_next_pulse = r_btn_db & ~r_btn_db_d;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [OW-1:0]     r_owner;
  logic [OW-1:0]     r_ptr;
  logic [HW-1:0]     r_hold;
  logic [N_SRC-1:0]  r_grant;
  logic [DATA_W-1:0] r_led;

  logic [0:0]        w_state_nxt;
  logic [OW-1:0]     w_owner_nxt;
  logic [OW-1:0]     w_ptr_nxt;
  logic [HW-1:0]     w_hold_nxt;
  logic [HW-1:0]     w_hold_dec;
  logic [N_SRC-1:0]  w_grant_nxt;
  logic [DATA_W-1:0] w_led_nxt;
  logic              w_regrant;

  logic [N_SRC-1:0]  w_owner_oh;
  logic [N_SRC-1:0]  w_mask;
  logic [OW-1:0]     w_scan_idx;
  logic              w_found;
  logic [OW-1:0]     w_win;
  logic [DATA_W-1:0] w_src_data [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign w_src_data[gi]  = i_data[gi*DATA_W +: DATA_W];
    assign w_owner_oh[gi]  = (r_owner == OW'(gi));
    assign w_grant_nxt[gi] = (w_state_nxt == c_SHOW) && (w_owner_nxt == OW'(gi));
  end

  // While showing, the current owner is excluded so a hit means "someone else".
  always_comb begin
    w_mask     = (r_state == c_SHOW) ? (i_req & ~w_owner_oh) : i_req;
    w_found    = 1'b0;
    w_win      = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_scan_idx = OW'((int'(r_ptr) + k) % N_SRC);
      if (!w_found && w_mask[w_scan_idx]) begin
        w_found = 1'b1;
        w_win   = w_scan_idx;
      end
    end
  end

  assign w_hold_dec = (r_hold != '0) ? (r_hold - HW'(1)) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_regrant   = 1'b0;
    if (r_state == c_IDLE) begin
      w_regrant = w_found;
    end else begin
      if (!i_req[r_owner]) begin
        if (w_found) begin
          w_regrant = 1'b1;
        end else begin
          w_state_nxt = c_IDLE;
          w_owner_nxt = '0;
          w_hold_nxt  = '0;
        end
      end else if (i_sw_lock) begin
        w_hold_nxt = w_hold_dec;
      end else if (w_next_pulse) begin
        if (w_found) begin
          w_regrant = 1'b1;
        end else begin
          w_hold_nxt = c_HOLD_RELOAD;
        end
      end else if ((r_hold == '0) && w_found) begin
        w_regrant = 1'b1;
      end else begin
        w_hold_nxt = w_hold_dec;
      end
    end
    if (w_regrant) begin
      w_state_nxt = c_SHOW;
      w_owner_nxt = w_win;
      w_ptr_nxt   = w_win;
      w_hold_nxt  = c_HOLD_RELOAD;
    end
  end

  // LEDs go dark on the very edge the bank becomes idle, never a stale frame.
  assign w_led_nxt = ((r_state == c_SHOW) && (w_state_nxt == c_SHOW)) ?
                     w_src_data[r_owner] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_owner <= '0;
      r_ptr   <= c_PTR_RESET;
      r_hold  <= '0;
      r_grant <= '0;
      r_led   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_grant <= w_grant_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign o_led    = r_led;
  assign o_grant  = r_grant;
  assign o_owner  = r_owner;
  assign o_active = (r_state == c_SHOW);

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bank_arbiter
// Brief    : Directed self-checking bench for led_bank_arbiter.
// Revision : 1.0
// ============================================================================
module tb_led_bank_arbiter;

  localparam int N_SRC           = 4;
  localparam int DATA_W          = 8;
  localparam int HOLD_CYCLES     = 8;
  localparam int DEBOUNCE_CYCLES = 4;

  logic                    clk;
  logic                    rst;
  logic [N_SRC-1:0]        i_req;
  logic [N_SRC*DATA_W-1:0] i_data;
  logic                    i_btn_next;
  logic                    i_sw_lock;
  logic [DATA_W-1:0]       o_led;
  logic [N_SRC-1:0]        o_grant;
  logic [1:0]              o_owner;
  logic                    o_active;

  int checks = 0;
  int errors = 0;

  led_bank_arbiter #(
    .N_SRC           (N_SRC),
    .DATA_W          (DATA_W),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_btn_next (i_btn_next),
    .i_sw_lock  (i_sw_lock),
    .o_led      (o_led),
    .o_grant    (o_grant),
    .o_owner    (o_owner),
    .o_active   (o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    i_req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (o_grant !== 4'b0000 || o_led !== 8'h00 || o_active !== 1'b0 || o_owner !== 2'd0) begin
        $display("FAIL reset_hold grant=%b led=%h active=%b owner=%0d required 0000/00/0/0",
                 o_grant, o_led, o_active, o_owner);
        errors++;
      end
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (o_grant !== 4'b0001 || o_owner !== 2'd0 || o_active !== 1'b1 || o_led !== 8'h00) begin
      $display("FAIL reset_first_grant grant=%b owner=%0d active=%b led=%h required 0001/0/1/00",
               o_grant, o_owner, o_active, o_led);
      errors++;
    end
    tick(1);
    checks++;
    if (o_led !== 8'h11) begin
      $display("FAIL reset_first_led led=%h required 11", o_led);
      errors++;
    end
  endtask

  task automatic test_rr_hold;
    i_req = 4'b1010;
    tick(1);
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      checks++;
      if (o_grant !== 4'b0010) begin
        $display("FAIL rr_hold_src1 cycle=%0d grant=%b required 0010", i, o_grant);
        errors++;
      end
      if (i == 1) begin
        checks++;
        if (o_led !== 8'h22) begin
          $display("FAIL rr_led_src1 led=%h required 22", o_led);
          errors++;
        end
      end
      tick(1);
    end
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      checks++;
      if (o_grant !== 4'b1000) begin
        $display("FAIL rr_hold_src3 cycle=%0d grant=%b required 1000", i, o_grant);
        errors++;
      end
      tick(1);
    end
    checks++;
    if (o_grant !== 4'b0010 || o_owner !== 2'd1) begin
      $display("FAIL rr_wrap grant=%b owner=%0d required 0010/1", o_grant, o_owner);
      errors++;
    end
  endtask

  task automatic test_sole_requester;
    i_req = 4'b0001;
    tick(1);
    checks++;
    if (o_grant !== 4'b0001) begin
      $display("FAIL sole_release grant=%b required 0001", o_grant);
      errors++;
    end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      checks++;
      if (o_grant !== 4'b0001) begin
        $display("FAIL sole_keep cycle=%0d grant=%b required 0001", i, o_grant);
        errors++;
      end
    end
    i_req = 4'b0101;
    tick(1);
    checks++;
    if (o_grant !== 4'b0100 || o_owner !== 2'd2) begin
      $display("FAIL sole_newcomer grant=%b owner=%0d required 0100/2", o_grant, o_owner);
      errors++;
    end
    tick(1);
    checks++;
    if (o_led !== 8'h33) begin
      $display("FAIL sole_newcomer_led led=%h required 33", o_led);
      errors++;
    end
  endtask

  task automatic test_debounce;
    i_req = 4'b0100;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      i_btn_next = 1'b1;
      tick(1);
      i_btn_next = 1'b0;
      tick(1);
    end
    // First stable-high sample; source 2 drops on the same edge so 3 gets a fresh hold.
    i_btn_next = 1'b1;
    i_req      = 4'b1001;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o_grant !== 4'b1000) begin
        $display("FAIL debounce_before cycle=%0d grant=%b required 1000", i, o_grant);
        errors++;
      end
      if (i == 5) i_btn_next = 1'b0;
      tick(1);
    end
    checks++;
    if (o_grant !== 4'b0001 || o_owner !== 2'd0) begin
      $display("FAIL debounce_advance grant=%b owner=%0d required 0001/0", o_grant, o_owner);
      errors++;
    end
    for (int i = 0; i < 7; i++) begin
      tick(1);
      checks++;
      if (o_grant !== 4'b0001) begin
        $display("FAIL debounce_single cycle=%0d grant=%b required 0001", i, o_grant);
        errors++;
      end
    end
  endtask

  task automatic test_lock;
    i_sw_lock  = 1'b1;
    i_req      = 4'b1111;
    i_btn_next = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 8) i_btn_next = 1'b0;
      checks++;
      if (o_grant !== 4'b0001) begin
        $display("FAIL lock_hold cycle=%0d grant=%b required 0001", i, o_grant);
        errors++;
      end
    end
    i_req = 4'b1110;
    tick(1);
    checks++;
    if (o_grant !== 4'b0010 || o_owner !== 2'd1 || o_active !== 1'b1) begin
      $display("FAIL lock_release grant=%b owner=%0d active=%b required 0010/1/1",
               o_grant, o_owner, o_active);
      errors++;
    end
    i_sw_lock = 1'b0;
  endtask

  task automatic test_reset_mid;
    tick(2);
    checks++;
    if (o_grant !== 4'b0010) begin
      $display("FAIL mid_pre_reset grant=%b required 0010", o_grant);
      errors++;
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (o_grant !== 4'b0000 || o_led !== 8'h00 || o_active !== 1'b0 || o_owner !== 2'd0) begin
      $display("FAIL mid_reset grant=%b led=%h active=%b owner=%0d required 0000/00/0/0",
               o_grant, o_led, o_active, o_owner);
      errors++;
    end
    rst   = 1'b1;
    i_req = 4'b1111;
    tick(1);
    checks++;
    if (o_grant !== 4'b0001 || o_owner !== 2'd0 || o_active !== 1'b1) begin
      $display("FAIL mid_ptr_reset grant=%b owner=%0d active=%b required 0001/0/1",
               o_grant, o_owner, o_active);
      errors++;
    end
  endtask

  initial begin
    rst        = 1'b0;
    i_req      = '0;
    i_data     = {8'h44, 8'h33, 8'h22, 8'h11};
    i_btn_next = 1'b0;
    i_sw_lock  = 1'b0;
    test_reset();
    test_rr_hold();
    test_sole_requester();
    test_debounce();
    test_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
